// File: rtl/mux_pkg.sv
// Shared helpers for the mux/arbiter family: select-width function and output-stage state type.
package mux_pkg;

    // Index width that never collapses to zero for single-channel instances.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

endpackage

// File: rtl/rr_arbiter_nb.sv
// Combinational round-robin arbiter: scans ptr+1, ptr+2, ... modulo CH.
// With ARB_MUX_FIXED_PRIO_EN defined it is fixed-priority (lowest index wins) and ptr is ignored.
module rr_arbiter_nb
    import mux_pkg::*;
#(
    parameter int CH = 3,
    parameter int SW = clog2_min1(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [CH-1:0] grant,
    output logic [SW-1:0] gidx,
    output logic          gany
);

    always_comb begin
        grant = '0;
        gidx  = '0;
        gany  = 1'b0;
`ifdef ARB_MUX_FIXED_PRIO_EN
        for (int i = 0; i < CH; i++) begin
            if (!gany && req[i]) begin
                grant[i] = 1'b1;
                gidx     = SW'(i);
                gany     = 1'b1;
            end
        end
`else
        for (int k = 1; k <= CH; k++) begin
            int idx;
            idx = (int'(ptr) + k) % CH;
            if (!gany && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = SW'(idx);
                gany       = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/arb_mux_nt1_nb.sv
// CH:1 arbitrated mux with valid/ready handshake, registered output and forced-select override.
// Define ARB_MUX_FIXED_PRIO_EN for a fixed-priority arbiter instead of round-robin.
module arb_mux_nt1_nb
    import mux_pkg::*;
#(
    parameter int n  = 32,
    parameter int CH = 3,
    localparam int SW = clog2_min1(CH)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   IN_VALID,
    input  logic [CH*n-1:0] IN_DATA,
    output logic [CH-1:0]   IN_READY,
    input  logic            FORCE_EN,
    input  logic [SW-1:0]   FORCE_SEL,
    output logic            OUT_VALID,
    output logic [n-1:0]    OUT_DATA,
    output logic [SW-1:0]   OUT_SEL,
    input  logic            OUT_READY
);

    out_state_t    r_state;
    logic [n-1:0]  r_data;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] w_ptr;

    logic          w_load;
    logic [CH-1:0] w_force_mask;
    logic [CH-1:0] w_elig;
    logic [CH-1:0] w_grant;
    logic [SW-1:0] w_gidx;
    logic          w_gany;
    logic [n-1:0]  w_sel_data;

    // An out-of-range FORCE_SEL matches no channel, leaving the eligible set empty.
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_mask
            assign w_force_mask[gi] = (FORCE_SEL == SW'(gi));
        end
    endgenerate

    assign w_elig   = FORCE_EN ? (IN_VALID & w_force_mask) : IN_VALID;
    assign w_load   = (r_state == OUT_EMPTY) || OUT_READY;
    assign IN_READY = w_grant & {CH{w_load}};

    rr_arbiter_nb #(.CH(CH), .SW(SW)) u_arb (
        .req   (w_elig),
        .ptr   (w_ptr),
        .grant (w_grant),
        .gidx  (w_gidx),
        .gany  (w_gany)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_grant[i]) begin
                w_sel_data = IN_DATA[i*n +: n];
            end
        end
    end

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [SW-1:0] r_ptr;

    // Forced transfers leave the rotation where it was.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= SW'(CH - 1);
        end else if (w_load && w_gany && !FORCE_EN) begin
            r_ptr <= w_gidx;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= OUT_EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_load) begin
            if (w_gany) begin
                r_state <= OUT_FULL;
                r_data  <= w_sel_data;
                r_sel   <= w_gidx;
            end else begin
                r_state <= OUT_EMPTY;
            end
        end
    end

    assign OUT_VALID = (r_state == OUT_FULL);
    assign OUT_DATA  = r_data;
    assign OUT_SEL   = r_sel;

endmodule

// File: tb/tb_arb_mux_nt1_nb.sv
// Scoreboard bench for arb_mux_nt1_nb (CH=3, n=32) with a queue-based reference model.
module tb_arb_mux_nt1_nb;

    localparam int N  = 32;
    localparam int CH = 3;
    localparam int SW = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [CH-1:0]   IN_VALID = '0;
    logic [CH*N-1:0] IN_DATA = '0;
    logic [CH-1:0]   IN_READY;
    logic            FORCE_EN = 1'b0;
    logic [SW-1:0]   FORCE_SEL = '0;
    logic            OUT_VALID;
    logic [N-1:0]    OUT_DATA;
    logic [SW-1:0]   OUT_SEL;
    logic            OUT_READY = 1'b0;

    arb_mux_nt1_nb #(.n(N), .CH(CH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_READY  (IN_READY),
        .FORCE_EN  (FORCE_EN),
        .FORCE_SEL (FORCE_SEL),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_SEL   (OUT_SEL),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0] d;
        int           s;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_ptr       = CH - 1;
    bit   m_full      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void set_data(input int ch, input logic [N-1:0] d);
        IN_DATA[ch*N +: N] = d;
    endfunction

    // One clock: judge handshake at the negedge, advance model, return at posedge+1.
    task automatic step();
        int  g;
        bit  load;
        logic [CH-1:0] exp_rdy;
        bit  elig [CH];
        @(negedge CLK);
        for (int i = 0; i < CH; i++)
            elig[i] = IN_VALID[i] && (!FORCE_EN || int'(FORCE_SEL) == i);
        g = -1;
`ifdef ARB_MUX_FIXED_PRIO_EN
        for (int i = CH - 1; i >= 0; i--)
            if (elig[i]) g = i;
`else
        for (int k = CH; k >= 1; k--)
            if (elig[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
`endif
        load    = !m_full || OUT_READY;
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(IN_READY), 64'(exp_rdy));
        check("out_valid", 64'(OUT_VALID), 64'(m_full));
        $display("cyc t=%0t vld=%b frc=%0d/%0d ordy=%b grant=%0d irdy=%b", $time, IN_VALID,
                 FORCE_EN, FORCE_SEL, OUT_READY, g, IN_READY);
        if (load) begin
            if (g >= 0) begin
                exp_t e;
                e.d = IN_DATA[g*N +: N];
                e.s = g;
                sb.push_back(e);
                m_full = 1'b1;
                if (!FORCE_EN) m_ptr = g;
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every held word must match the oldest pending expectation; it retires on handshake.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_unexpected: got data %0h sel %0d with nothing expected", OUT_DATA, OUT_SEL);
            end else begin
                check("out_data", 64'(OUT_DATA), 64'(sb[0].d));
                check("out_sel", 64'(OUT_SEL), 64'(sb[0].s));
                if (OUT_READY) void'(sb.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Round-robin rotation from reset with all channels valid.
        set_data(0, 32'h11); set_data(1, 32'h22); set_data(2, 32'h33);
        IN_VALID  = 3'b111;
        OUT_READY = 1'b1;
        repeat (6) step();

        // Backpressure while inputs keep changing.
        OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 3'($urandom_range(1, 7));
            set_data(i % CH, $urandom);
            step();
        end
        OUT_READY = 1'b1;
        repeat (2) step();

        // Forced channel 2, then release, then out-of-range force.
        set_data(0, 32'h11); set_data(1, 32'h22); set_data(2, 32'h33);
        IN_VALID  = 3'b111;
        FORCE_EN  = 1'b1;
        FORCE_SEL = 2'd2;
        repeat (3) step();
        FORCE_EN = 1'b0;
        repeat (2) step();
        FORCE_EN  = 1'b1;
        FORCE_SEL = 2'd3;
        repeat (2) step();
        FORCE_EN = 1'b0;

        // Sparse traffic: channel 1 valid every other cycle.
        for (int i = 0; i < 8; i++) begin
            IN_VALID = (i % 2 == 0) ? 3'b010 : 3'b000;
            set_data(1, 32'h100 + 32'(i));
            step();
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            IN_VALID  = 3'($urandom_range(0, 7));
            for (int c = 0; c < CH; c++) set_data(c, $urandom);
            FORCE_EN  = ($urandom_range(0, 4) == 0);
            FORCE_SEL = 2'($urandom_range(0, 3));
            OUT_READY = ($urandom_range(0, 9) < 7);
            step();
        end
        FORCE_EN = 1'b0;

        // Asynchronous reset while a word is held under backpressure.
        IN_VALID  = 3'b001;
        set_data(0, 32'hDEADBEEF);
        OUT_READY = 1'b1;
        step();
        IN_VALID  = 3'b000;
        OUT_READY = 1'b0;
        step();
        check("hold_before_reset", 64'(OUT_DATA), 64'(32'hDEADBEEF));
        #2 RST = 1'b1;
        #1;
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out_data", 64'(OUT_DATA), 64'd0);
        check("rst_out_sel", 64'(OUT_SEL), 64'd0);
        sb.delete();
        m_full = 1'b0;
        m_ptr  = CH - 1;
        #3 RST = 1'b0;
        @(posedge CLK);
        #1;
        set_data(0, 32'hA0); set_data(1, 32'hA1); set_data(2, 32'hA2);
        IN_VALID  = 3'b111;
        OUT_READY = 1'b1;
        repeat (4) step();

        // Drain and confirm nothing was left undelivered.
        IN_VALID = 3'b000;
        repeat (3) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
